// File: rtl/fg_island_prog_sequencer.sv
// Floating-gate island programming sequencer: settle, a cycle-exact pulse/gap
// train, then release. All outputs are registered from the next-state decode.
module fg_island_prog_sequencer #(
  parameter int ROW_BITS   = 3,
  parameter int COL_BITS   = 4,
  parameter int CNT_BITS   = 6,
  parameter int PW_BITS    = 8,
  parameter int SETTLE_CYC = 4,
  parameter int GAP_CYC    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ROW_BITS-1:0] cmd_row,
  input  logic [COL_BITS-1:0] cmd_col,
  input  logic [CNT_BITS-1:0] cmd_npulse,
  input  logic [PW_BITS-1:0]  cmd_width,
  input  logic                abort,
  output logic [ROW_BITS-1:0] row_addr,
  output logic [COL_BITS-1:0] col_addr,
  output logic                dec_en,
  output logic                prog_mode,
  output logic                inj_pulse,
  output logic                busy,
  output logic                done,
  output logic                done_aborted,
  output logic [CNT_BITS-1:0] pulses_done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETTLE  = 3'd1;
  localparam logic [2:0] PULSE   = 3'd2;
  localparam logic [2:0] GAP     = 3'd3;
  localparam logic [2:0] RELEASE = 3'd4;

  localparam int SW  = $clog2(SETTLE_CYC + 1);
  localparam int GW  = $clog2(GAP_CYC + 1);
  localparam int CW0 = (PW_BITS > SW) ? PW_BITS : SW;
  localparam int CW  = (CW0 > GW) ? CW0 : GW;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYC - 1);

  logic [2:0]          state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [PW_BITS-1:0]  wid_m1;
  logic [CNT_BITS-1:0] npulse_r;
  logic [CNT_BITS-1:0] pdone_nx;
  logic                aborted, aborted_nx;
  logic                accept, finish;

  // cnt holds the remaining cycles minus one of the current phase.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pdone_nx   = pulses_done;
    aborted_nx = aborted;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_nx   = SETTLE;
          cnt_nx     = SETTLE_LD;
          pdone_nx   = '0;
          aborted_nx = 1'b0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nx   = RELEASE;
          cnt_nx     = SETTLE_LD;
          aborted_nx = 1'b1;
        end else if (cnt == '0) begin
          if (npulse_r != '0) begin
            state_nx = PULSE;
            cnt_nx   = CW'(wid_m1);
          end else begin
            state_nx = RELEASE;
            cnt_nx   = SETTLE_LD;
          end
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      PULSE: begin
        // A pulse whose final cycle coincides with abort has run its full width and counts.
        if (cnt == '0) begin
          pdone_nx = pulses_done + CNT_BITS'(1);
          if (abort || pdone_nx == npulse_r) begin
            state_nx   = RELEASE;
            cnt_nx     = SETTLE_LD;
            aborted_nx = abort;
          end else begin
            state_nx = GAP;
            cnt_nx   = GAP_LD;
          end
        end else if (abort) begin
          state_nx   = RELEASE;
          cnt_nx     = SETTLE_LD;
          aborted_nx = 1'b1;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_nx   = RELEASE;
          cnt_nx     = SETTLE_LD;
          aborted_nx = 1'b1;
        end else if (cnt == '0) begin
          state_nx = PULSE;
          cnt_nx   = CW'(wid_m1);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      RELEASE: begin
        if (cnt == '0) begin
          state_nx = IDLE;
          finish   = 1'b1;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      wid_m1       <= '0;
      npulse_r     <= '0;
      aborted      <= 1'b0;
      row_addr     <= '0;
      col_addr     <= '0;
      pulses_done  <= '0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      prog_mode    <= 1'b0;
      dec_en       <= 1'b0;
      inj_pulse    <= 1'b0;
      done         <= 1'b0;
      done_aborted <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      aborted      <= aborted_nx;
      pulses_done  <= pdone_nx;
      if (accept) begin
        row_addr <= cmd_row;
        col_addr <= cmd_col;
        npulse_r <= cmd_npulse;
        wid_m1   <= (cmd_width == '0) ? '0 : cmd_width - PW_BITS'(1);
      end
      cmd_ready    <= (state_nx == IDLE);
      busy         <= (state_nx != IDLE);
      prog_mode    <= (state_nx != IDLE);
      dec_en       <= (state_nx == PULSE) || (state_nx == GAP);
      inj_pulse    <= (state_nx == PULSE);
      done         <= finish;
      done_aborted <= finish & aborted;
    end
  end

endmodule

// File: tb/tb_fg_island_prog_sequencer.sv
// Directed and randomized checks of fg_island_prog_sequencer against a
// cycle-timeline model derived from the pulse schedule.
module tb_fg_island_prog_sequencer;

  localparam int ROW_BITS = 3;
  localparam int COL_BITS = 4;
  localparam int CNT_BITS = 6;
  localparam int PW_BITS  = 8;
  localparam int S        = 4;
  localparam int G        = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [ROW_BITS-1:0] cmd_row = '0;
  logic [COL_BITS-1:0] cmd_col = '0;
  logic [CNT_BITS-1:0] cmd_npulse = '0;
  logic [PW_BITS-1:0]  cmd_width = '0;
  logic                abort = 1'b0;
  logic [ROW_BITS-1:0] row_addr;
  logic [COL_BITS-1:0] col_addr;
  logic                dec_en, prog_mode, inj_pulse, busy, done, done_aborted;
  logic [CNT_BITS-1:0] pulses_done;

  int tests = 0;
  int failed = 0;

  fg_island_prog_sequencer #(
    .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .CNT_BITS(CNT_BITS),
    .PW_BITS(PW_BITS), .SETTLE_CYC(S), .GAP_CYC(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_npulse(cmd_npulse),
    .cmd_width(cmd_width), .abort(abort), .row_addr(row_addr),
    .col_addr(col_addr), .dec_en(dec_en), .prog_mode(prog_mode),
    .inj_pulse(inj_pulse), .busy(busy), .done(done),
    .done_aborted(done_aborted), .pulses_done(pulses_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Timeline model: cycle k counts from the accept edge; abort at cycle a
  // is sampled at the end of that cycle.
  function automatic int phase_end(input int n, input int w);
    return (n == 0) ? S : S + n * w + (n - 1) * G;
  endfunction

  function automatic void model(input int n, input int w, input int a,
                                output int d, output int pd, output bit ab);
    int pe = phase_end(n, w);
    if (a >= 1 && a <= pe) begin
      ab = 1'b1;
      d  = a + S + 1;
      pd = 0;
      for (int k = 0; k < n; k++)
        if (S + 1 + k * (w + G) + w - 1 <= a) pd++;
    end else begin
      ab = 1'b0;
      d  = pe + S + 1;
      pd = n;
    end
  endfunction

  function automatic logic [5:0] exp_vec(input int c, input int n, input int w,
                                         input int d, input int a, input bit ab);
    int lim = ab ? a : phase_end(n, w);
    bit inj = 1'b0;
    bit dec;
    for (int k = 0; k < n; k++) begin
      int st = S + 1 + k * (w + G);
      if (c >= st && c <= st + w - 1 && c <= lim) inj = 1'b1;
    end
    dec = (n > 0) && (c >= S + 1) && (c <= lim);
    // {inj_pulse, dec_en, prog_mode, done, busy, cmd_ready}
    return {inj, dec, c < d, c == d, c < d, c == d};
  endfunction

  // Called right after the accept edge; returns at the falling edge of the done cycle.
  task automatic run_check(input int row, input int col, input int n,
                           input int wraw, input int a);
    int w = (wraw == 0) ? 1 : wraw;
    int d, pd;
    bit ab;
    model(n, w, a, d, pd, ab);
    for (int c = 1; c <= d; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_valid  = 1'b0;
        cmd_row    = ROW_BITS'($urandom);
        cmd_col    = COL_BITS'($urandom);
        cmd_npulse = CNT_BITS'($urandom);
        cmd_width  = PW_BITS'($urandom);
      end
      abort = (c == a);
      chk($sformatf("cyc%0d n%0d w%0d a%0d", c, n, wraw, a),
          32'({inj_pulse, dec_en, prog_mode, done, busy, cmd_ready}),
          32'(exp_vec(c, n, w, d, a, ab)));
      if (c == 1 || c == d) begin
        chk("row_addr", 32'(row_addr), 32'(row));
        chk("col_addr", 32'(col_addr), 32'(col));
      end
      if (c == d) begin
        chk("pulses_done", 32'(pulses_done), 32'(pd));
        chk("done_aborted", 32'(done_aborted), 32'(ab));
      end
    end
  endtask

  task automatic do_cmd(input int row, input int col, input int n,
                        input int wraw, input int a, input bit chained);
    if (!chained) begin
      @(negedge clk);
      abort = 1'b0;
    end
    cmd_row    = ROW_BITS'(row);
    cmd_col    = COL_BITS'(col);
    cmd_npulse = CNT_BITS'(n);
    cmd_width  = PW_BITS'(wraw);
    cmd_valid  = 1'b1;
    @(posedge clk);
    run_check(row, col, n, wraw, a);
  endtask

  initial begin
    int n, w, a, d, pd;
    bit ab;
    #12;
    chk("reset_vec", 32'({inj_pulse, dec_en, prog_mode, done, busy, cmd_ready}), 32'b000001);
    chk("reset_addr", 32'({row_addr, col_addr, pulses_done, done_aborted}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_cmd(5, 9, 2, 3, 0, 1'b0);    // nominal
    do_cmd(2, 3, 0, 7, 0, 1'b0);    // zero pulses
    do_cmd(1, 4, 1, 0, 0, 1'b0);    // zero width treated as one
    do_cmd(5, 9, 2, 3, 11, 1'b0);   // abort mid second pulse
    do_cmd(6, 1, 3, 2, 2, 1'b0);    // abort in settle
    do_cmd(5, 9, 2, 3, 15, 1'b0);   // abort during release is ignored
    do_cmd(7, 15, 2, 3, 17, 1'b0);  // abort in done cycle alongside next accept
    do_cmd(3, 12, 1, 2, 0, 1'b1);   // back-to-back accept
    do_cmd(0, 0, 63, 1, 0, 1'b0);   // maximum pulse count

    for (int i = 0; i < 14; i++) begin
      n = $urandom_range(0, 5);
      w = $urandom_range(0, 4);
      model(n, (w == 0) ? 1 : w, 0, d, pd, ab);
      a = ($urandom_range(0, 1) == 1) ? $urandom_range(1, d) : 0;
      do_cmd($urandom_range(0, 7), $urandom_range(0, 15), n, w, a,
             1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a pulse
    @(negedge clk);
    abort = 1'b0;
    cmd_row = 3'd5; cmd_col = 4'd9; cmd_npulse = 6'd2; cmd_width = 8'd3;
    cmd_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    chk("pre_reset_inj", 32'({inj_pulse, dec_en, prog_mode}), 32'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_vec", 32'({inj_pulse, dec_en, prog_mode, done, busy, cmd_ready}), 32'b000001);
    chk("async_reset_pd", 32'(pulses_done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_reset_idle", 32'({inj_pulse, dec_en, prog_mode, done, busy, cmd_ready}), 32'b000001);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fg_island_prog_sequencer.md
# fg_island_prog_sequencer

Sequences floating-gate programming of one FG island. Accepts one (row, column, pulse-count, pulse-width) command at a time and drives the vertical decoder address, the horizontal decoder address and enables, the prog-switch/drain-select mode line, and the injection pulse. The pulse train is a fixed, cycle-exact schedule. The block sits between the on-chip programming command source and the island's decoder/switch periphery. It is the only agent that moves the island out of run mode.

## Interface
- ROW_BITS, 3: vertical decoder address width.
- COL_BITS, 4: horizontal decoder address width.
- CNT_BITS, 6: pulse-count width.
- PW_BITS, 8: pulse-width width, in clocks.
- SETTLE_CYC, 4: address/switch settle time, in clocks; applies before the first pulse and again during release.
- GAP_CYC, 2: off time between consecutive pulses, in clocks.

Clocking and reset (already decided): one clock, `clk`. Reset `rst_n` is asynchronous and active-low.

- clk  in  1  clock
- rst_n  in  1  async active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_row  in  ROW_BITS  target row
- cmd_col  in  COL_BITS  target column
- cmd_npulse  in  CNT_BITS  number of injection pulses
- cmd_width  in  PW_BITS  pulse width; 0 is treated as 1
- abort  in  1  terminate the current command safely
- row_addr  out  ROW_BITS  vertical decoder address
- col_addr  out  COL_BITS  horizontal decoder address
- dec_en  out  1  decoder enable, both decoders
- prog_mode  out  1  switches island to program configuration
- inj_pulse  out  1  injection pulse to the selected FG cell
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion strobe
- done_aborted  out  1  valid with done; command was aborted
- pulses_done  out  CNT_BITS  pulses completed by the last command; held until the next accept

## Operation
- States: IDLE, SETTLE, PULSE, GAP, RELEASE.
- IDLE
  - cmd_ready=1.
  - When cmd_valid is high, the command is accepted at that edge: latch row, col, npulse and width; clear pulses_done; go to SETTLE.
- SETTLE
  - Runs SETTLE_CYC cycles with prog_mode=1, dec_en=0 and addresses driven.
  - Exit to PULSE if npulse≠0, else to RELEASE.
- PULSE
  - Runs width cycles with dec_en=1 and inj_pulse=1.
  - At the end, increment pulses_done.
  - If pulses_done reaches npulse, go to RELEASE; otherwise go to GAP.
- GAP
  - Runs GAP_CYC cycles with dec_en=1 and inj_pulse=0, then returns to PULSE.
- RELEASE
  - Runs SETTLE_CYC cycles with inj_pulse=0, dec_en=0, prog_mode=1, then goes to IDLE.
- Entering IDLE from RELEASE:
  - prog_mode=0 and done=1 for exactly one cycle.
  - done_aborted is valid in the same cycle.
  - cmd_ready=1 in the same cycle; back-to-back accept is allowed.
- abort, sampled high in SETTLE, PULSE or GAP:
  - The next state is RELEASE with the full SETTLE_CYC count.
  - inj_pulse and dec_en are 0 starting the next cycle.
  - done_aborted=1 at completion.
  - pulses_done keeps the count of pulses fully completed. A truncated pulse is not counted.
- abort is ignored in IDLE and RELEASE. abort and cmd_valid high together in IDLE: the command is accepted.
- Outputs are registered. row_addr and col_addr hold their last values in IDLE.
- Counters are sized for the maximum count. There is no wrap: npulse=2^CNT_BITS−1 runs to completion.

## Timing
- Reset values: state=IDLE, cmd_ready=1, busy=0, done=0, done_aborted=0, prog_mode=0, dec_en=0, inj_pulse=0, row_addr=0, col_addr=0, pulses_done=0.
- Reset asserted mid-command: all outputs go to reset values asynchronously, so inj_pulse drops immediately. No done strobe is produced.
- Accept edge = E0; cycle k is the k-th cycle after E0.
  - SETTLE: cycles 1..S.
  - First pulse: cycles S+1..S+W.
  - Each following pulse starts after GAP_CYC gap cycles.
  - Total latency = 2S + N·W + (N−1)·G + 1 cycles to done, for N≥1.
  - For N=0: 2S+1.
- cmd_* must be stable only at the accept edge.

## Test plan
- Nominal (S=4, G=2), row=5, col=9, npulse=2, width=3:
  - row_addr=5 and col_addr=9 from cycle 1.
  - inj_pulse in cycles 5–7 and 10–12; dec_en in cycles 5–12.
  - done in cycle 17 with pulses_done=2, done_aborted=0, prog_mode=0.
- npulse=0: inj_pulse and dec_en never assert; done in cycle 9.
- width=0 with npulse=1: one 1-cycle pulse in cycle 5; done in cycle 10.
- abort in cycle 11 of the nominal command:
  - inj_pulse=0 from cycle 12; RELEASE runs cycles 12–15.
  - done in cycle 16 with done_aborted=1, pulses_done=1.
- Back-to-back: cmd_valid held high with a second command. It is accepted in the done cycle, so SETTLE restarts at the next cycle and there is no extra IDLE cycle.
- rst_n low during PULSE: inj_pulse, dec_en and prog_mode drop the same cycle with no clock edge. After release: IDLE, cmd_ready=1, no done strobe.
